// File: rtl/mem_resp_bank.sv
// Purpose : write-captured register bank (2**AW x BW) with a registered readback port.
// Latency : writes visible to reads accepted on the next edge; read data valid the cycle after grant.
// Backpress: one-entry output stage; rd_rdy=0 holds rd_data and stalls new requests (rd_gnt=0).
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   mem_wr, mem_addr, mem_data    write bus (mem_wr qualifies the cycle)
//   rd_req, rd_addr, rd_gnt       read request / combinational accept
//   rd_vld, rd_data, rd_rdy       registered read output with valid/ready handshake
//   wr_map                        per-entry "written since reset" flags
//   wr_cnt                        saturating count of accepted writes
//
// Optional feature: define MEM_RESP_BYPASS_EN to forward same-edge write data
// to a read of the same address; otherwise such a read returns the old contents.
module mem_resp_bank #(
    parameter int BW = 8,
    parameter int AW = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_wr,
    input  logic [AW-1:0]     mem_addr,
    input  logic [BW-1:0]     mem_data,
    input  logic              rd_req,
    input  logic [AW-1:0]     rd_addr,
    output logic              rd_gnt,
    output logic              rd_vld,
    output logic [BW-1:0]     rd_data,
    input  logic              rd_rdy,
    output logic [2**AW-1:0]  wr_map,
    output logic [15:0]       wr_cnt
);

    localparam int NE = 2**AW;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            rd_load;
    logic [BW-1:0]   rd_src;
    logic [BW-1:0]   bank [NE];

    // Write side: bank, written-map and saturating write counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NE; i++) begin
                bank[i] <= '0;
            end
            wr_map <= '0;
            wr_cnt <= '0;
        end else if (mem_wr) begin
            bank[mem_addr]   <= mem_data;
            wr_map[mem_addr] <= 1'b1;
            if (wr_cnt != 16'hFFFF) begin
                wr_cnt <= wr_cnt + 16'd1;
            end
        end
    end

    // Read source. Forwarding only touches the data path; rd_gnt stays
    // independent of the write bus.
    always_comb begin
        rd_src = bank[rd_addr];
`ifdef MEM_RESP_BYPASS_EN
        if (mem_wr && (mem_addr == rd_addr)) begin
            rd_src = mem_data;
        end
`endif
    end

    // Output stage state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and accept logic. A full stage can be reloaded in the same
    // cycle its content is consumed, giving one read per cycle.
    always_comb begin
        state_nxt = state;
        rd_load   = 1'b0;
        rd_gnt    = 1'b0;
        case (state)
            ST_EMPTY: begin
                rd_gnt = rd_req;
                if (rd_req) begin
                    state_nxt = ST_FULL;
                    rd_load   = 1'b1;
                end
            end
            ST_FULL: begin
                rd_gnt = rd_req & rd_rdy;
                if (rd_rdy) begin
                    if (rd_req) begin
                        rd_load = 1'b1;
                    end else begin
                        state_nxt = ST_EMPTY;
                    end
                end
            end
            default: begin
                state_nxt = ST_EMPTY;
            end
        endcase
    end

    assign rd_vld = (state == ST_FULL);

    // Captured data is a snapshot; later writes to the same entry do not alter it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_load) begin
            rd_data <= rd_src;
        end
    end

endmodule
